// File: rtl/anti_theft_fsm_if.sv
// Sensor, configuration and countdown-timer signals of the car-alarm controller.
// FUEL_PUMP_EN adds the hidden-switch / brake-pedal immobiliser signals.
interface anti_theft_fsm_if;
  logic       ignition;
  logic       door_driver;
  logic       door_passenger;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       one_hz_enable;
  logic       expired;
  logic       start_timer;
  logic [3:0] interval;
  logic       siren_on;
  logic       status_led;
  logic [2:0] state_dbg;
`ifdef FUEL_PUMP_EN
  logic       hidden_switch;
  logic       brake_pedal;
  logic       fuel_pump_on;
`endif

  modport master (
    output ignition, door_driver, door_passenger, reprogram, time_param_sel,
           time_value, one_hz_enable, expired,
`ifdef FUEL_PUMP_EN
    output hidden_switch, brake_pedal,
    input  fuel_pump_on,
`endif
    input  start_timer, interval, siren_on, status_led, state_dbg
  );

  modport slave (
    input  ignition, door_driver, door_passenger, reprogram, time_param_sel,
           time_value, one_hz_enable, expired,
`ifdef FUEL_PUMP_EN
    input  hidden_switch, brake_pedal,
    output fuel_pump_on,
`endif
    output start_timer, interval, siren_on, status_led, state_dbg
  );
endinterface

// File: rtl/anti_theft_fsm.sv
// Car-alarm arm/trigger/alarm/disarm sequencer driving an external countdown timer.
// Optional immobiliser output enabled by defining FUEL_PUMP_EN.
//
// state          | meaning
// ARMED          | waiting for a door or ignition, LED blinks
// TRIGGERED      | door opened, entry countdown running
// SOUND          | siren on while any door is open
// HOLD           | siren held for the alarm time after doors close
// DIS_IGN        | ignition on, disarmed
// DIS_WAIT_OPEN  | ignition off, waiting for driver to get out
// DIS_WAIT_CLOSE | waiting for all doors closed
// ARMING         | arming delay running
module anti_theft_fsm #(
  parameter logic [3:0] T_ARM_DEF       = 4'd6,
  parameter logic [3:0] T_DRIVER_DEF    = 4'd8,
  parameter logic [3:0] T_PASSENGER_DEF = 4'd15,
  parameter logic [3:0] T_ALARM_DEF     = 4'd10
) (
  input  logic          clock_25mhz,
  input  logic          reset_sync_n,
  anti_theft_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    ARMED          = 3'd0,
    TRIGGERED      = 3'd1,
    SOUND          = 3'd2,
    HOLD           = 3'd3,
    DIS_IGN        = 3'd4,
    DIS_WAIT_OPEN  = 3'd5,
    DIS_WAIT_CLOSE = 3'd6,
    ARMING         = 3'd7
  } state_t;

  localparam logic [1:0] SEL_ARM = 2'd0, SEL_DRIVER = 2'd1, SEL_PASSENGER = 2'd2, SEL_ALARM = 2'd3;

  state_t     r_state;
  logic       r_start;
  logic [3:0] r_interval;
  logic       r_siren;
  logic       r_led;
  logic [3:0] r_tparam [4];

  state_t     w_next;
  logic       w_start;
  logic [3:0] w_interval;
  logic       w_led;
  logic       w_exp_q;
  logic       w_any_door;

  // The flag is stale in the cycle right after a start pulse.
  assign w_exp_q    = bus.expired & ~r_start;
  assign w_any_door = bus.door_driver | bus.door_passenger;

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_interval = r_interval;
    case (r_state)
      ARMED: begin
        if (bus.ignition) w_next = DIS_IGN;
        else if (bus.door_driver) begin
          w_next = TRIGGERED; w_start = 1'b1; w_interval = r_tparam[SEL_DRIVER];
        end else if (bus.door_passenger) begin
          w_next = TRIGGERED; w_start = 1'b1; w_interval = r_tparam[SEL_PASSENGER];
        end
      end
      TRIGGERED: begin
        if (bus.ignition) w_next = DIS_IGN;
        else if (w_exp_q) w_next = SOUND;
      end
      SOUND: begin
        if (bus.ignition) w_next = DIS_IGN;
        else if (!w_any_door) begin
          w_next = HOLD; w_start = 1'b1; w_interval = r_tparam[SEL_ALARM];
        end
      end
      HOLD: begin
        if (bus.ignition) w_next = DIS_IGN;
        else if (w_any_door) w_next = SOUND;
        else if (w_exp_q) w_next = ARMED;
      end
      DIS_IGN: begin
        if (!bus.ignition) w_next = DIS_WAIT_OPEN;
      end
      DIS_WAIT_OPEN: begin
        if (bus.ignition) w_next = DIS_IGN;
        else if (bus.door_driver) w_next = DIS_WAIT_CLOSE;
      end
      DIS_WAIT_CLOSE: begin
        if (bus.ignition) w_next = DIS_IGN;
        else if (!w_any_door) begin
          w_next = ARMING; w_start = 1'b1; w_interval = r_tparam[SEL_ARM];
        end
      end
      ARMING: begin
        if (bus.ignition) w_next = DIS_IGN;
        else if (w_any_door) w_next = DIS_WAIT_CLOSE;
        else if (w_exp_q) w_next = ARMED;
      end
      default: w_next = ARMED;
    endcase
  end

  always_comb begin
    w_led = 1'b0;
    case (w_next)
      ARMED:                 w_led = (r_state == ARMED) ? (r_led ^ bus.one_hz_enable) : 1'b0;
      TRIGGERED, SOUND, HOLD: w_led = 1'b1;
      default:               w_led = 1'b0;
    endcase
  end

  always_ff @(posedge clock_25mhz) begin
    if (!reset_sync_n) begin
      r_state               <= ARMED;
      r_start               <= 1'b0;
      r_interval            <= 4'd0;
      r_siren               <= 1'b0;
      r_led                 <= 1'b0;
      r_tparam[SEL_ARM]       <= T_ARM_DEF;
      r_tparam[SEL_DRIVER]    <= T_DRIVER_DEF;
      r_tparam[SEL_PASSENGER] <= T_PASSENGER_DEF;
      r_tparam[SEL_ALARM]     <= T_ALARM_DEF;
    end else if (bus.reprogram) begin
      r_tparam[bus.time_param_sel] <= bus.time_value;
      r_state <= ARMED;
      r_start <= 1'b0;
      r_siren <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_start    <= w_start;
      r_interval <= w_interval;
      r_siren    <= (w_next == SOUND) || (w_next == HOLD);
      r_led      <= w_led;
    end
  end

  assign bus.start_timer = r_start;
  assign bus.interval    = r_interval;
  assign bus.siren_on    = r_siren;
  assign bus.status_led  = r_led;
  assign bus.state_dbg   = r_state;

`ifdef FUEL_PUMP_EN
  logic r_fuel_pump;

  // Latches on the hidden arming combination, then rides on ignition alone.
  always_ff @(posedge clock_25mhz) begin
    if (!reset_sync_n || bus.reprogram) r_fuel_pump <= 1'b0;
    else r_fuel_pump <= bus.ignition & (r_fuel_pump | (bus.hidden_switch & bus.brake_pedal));
  end

  assign bus.fuel_pump_on = r_fuel_pump;
`endif

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Directed bench for anti_theft_fsm with a queue of expected outputs per clock.
// Defining FUEL_PUMP_EN also exercises the immobiliser output.
module tb_anti_theft_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_err = 0;
  int   n_checks = 0;

  anti_theft_fsm_if bus();

  anti_theft_fsm dut (
    .clock_25mhz  (clk),
    .reset_sync_n (rst_n),
    .bus          (bus)
  );

  always #20 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       start;
    logic [3:0] iv;
    logic       siren;
    logic       led;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic start,
                     input logic [3:0] iv, input logic siren, input logic led);
    exp_t e;
    sb_q.push_back('{tag, st, start, iv, siren, led});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({e.tag, ".state"}, {5'd0, bus.state_dbg}, {5'd0, e.st});
    chk({e.tag, ".start"}, {7'd0, bus.start_timer}, {7'd0, e.start});
    chk({e.tag, ".interval"}, {4'd0, bus.interval}, {4'd0, e.iv});
    chk({e.tag, ".siren"}, {7'd0, bus.siren_on}, {7'd0, e.siren});
    chk({e.tag, ".led"}, {7'd0, bus.status_led}, {7'd0, e.led});
  endtask

  initial begin
    bus.ignition = 0; bus.door_driver = 0; bus.door_passenger = 0;
    bus.reprogram = 0; bus.time_param_sel = 0; bus.time_value = 0;
    bus.one_hz_enable = 0; bus.expired = 0;
`ifdef FUEL_PUMP_EN
    bus.hidden_switch = 0; bus.brake_pedal = 0;
`endif
    // reset, including priority over a door opening
    cyc("rst", 0, 0, 0, 0, 0);
    bus.door_passenger = 1; bus.one_hz_enable = 1;
    cyc("rst_pri", 0, 0, 0, 0, 0);
    bus.door_passenger = 0; bus.one_hz_enable = 0; rst_n = 1;
    for (int i = 0; i < 5; i++) cyc("idle", 0, 0, 0, 0, 0);
    bus.one_hz_enable = 1; cyc("blink1", 0, 0, 0, 0, 1);
    bus.one_hz_enable = 0; cyc("blink_hold", 0, 0, 0, 0, 1);
    bus.one_hz_enable = 1; cyc("blink2", 0, 0, 0, 0, 0);
    bus.one_hz_enable = 0;

    // passenger trigger -> sound -> hold -> armed
    bus.door_passenger = 1; cyc("trig_p", 1, 1, 15, 0, 1);
    for (int i = 0; i < 9; i++) cyc("count_p", 1, 0, 15, 0, 1);
    bus.expired = 1; cyc("sound", 2, 0, 15, 1, 1);
    cyc("sound_door", 2, 0, 15, 1, 1);
    bus.door_passenger = 0; cyc("hold_start", 3, 1, 10, 1, 1);
    cyc("hold_mask", 3, 0, 10, 1, 1);
    bus.expired = 0; cyc("hold", 3, 0, 10, 1, 1);
    bus.expired = 1; cyc("hold_exp", 0, 0, 10, 0, 0);
    bus.expired = 0;

    // both doors: driver wins; ignition beats expiry
    bus.door_driver = 1; bus.door_passenger = 1; cyc("both_doors", 1, 1, 8, 0, 1);
    bus.door_driver = 0; bus.door_passenger = 0; cyc("trig_d", 1, 0, 8, 0, 1);
    bus.ignition = 1; bus.expired = 1; cyc("ign_pri", 4, 0, 8, 0, 0);
    bus.expired = 0; cyc("dis_ign", 4, 0, 8, 0, 0);

    // disarm and re-arm
    bus.ignition = 0; cyc("dis_wait_open", 5, 0, 8, 0, 0);
    bus.door_driver = 1; cyc("dis_wait_close", 6, 0, 8, 0, 0);
    bus.door_driver = 0; cyc("arming", 7, 1, 6, 0, 0);
    cyc("arming_wait", 7, 0, 6, 0, 0);
    bus.door_passenger = 1; cyc("arming_door", 6, 0, 6, 0, 0);
    bus.door_passenger = 0; cyc("rearm", 7, 1, 6, 0, 0);
    bus.expired = 1; cyc("rearm_mask", 7, 0, 6, 0, 0);
    cyc("armed_again", 0, 0, 6, 0, 0);
    bus.expired = 0;

    // reprogram in SOUND overrides the HOLD start
    bus.door_driver = 1; cyc("trig_d2", 1, 1, 8, 0, 1);
    bus.door_driver = 0; cyc("count_d2", 1, 0, 8, 0, 1);
    bus.expired = 1; cyc("sound2", 2, 0, 8, 1, 1);
    bus.expired = 0; bus.reprogram = 1; bus.time_param_sel = 1; bus.time_value = 3;
    cyc("reprog", 0, 0, 8, 0, 0);
    bus.reprogram = 0; bus.time_param_sel = 0; bus.time_value = 0;
    bus.door_driver = 1; bus.expired = 1; cyc("trig_new", 1, 1, 3, 0, 1);
    bus.door_driver = 0; cyc("new_mask", 1, 0, 3, 0, 1);
    cyc("new_sound", 2, 0, 3, 1, 1);
    bus.expired = 0;

    // reset beats the pending HOLD start and reloads parameters
    rst_n = 0; cyc("rst_mid", 0, 0, 0, 0, 0);
    rst_n = 1; bus.door_driver = 1; cyc("param_reload", 1, 1, 8, 0, 1);
    bus.door_driver = 0;

`ifdef FUEL_PUMP_EN
    bus.ignition = 1; bus.hidden_switch = 1; bus.brake_pedal = 1;
    cyc("fuel_set", 4, 0, 8, 0, 0);
    chk("fuel_set", {7'd0, bus.fuel_pump_on}, 8'd1);
    bus.hidden_switch = 0; bus.brake_pedal = 0;
    cyc("fuel_hold", 4, 0, 8, 0, 0);
    chk("fuel_hold", {7'd0, bus.fuel_pump_on}, 8'd1);
    bus.ignition = 0;
    cyc("fuel_clear", 5, 0, 8, 0, 0);
    chk("fuel_clear", {7'd0, bus.fuel_pump_on}, 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
